// File: rtl/cache_controller_if.sv
// Requester-side bus of cache_controller: read/write strobes, word address,
// write data and registered read data.
interface cache_controller_if;
  logic        rd;
  logic        wr;
  logic [15:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output rd, output wr, output addr, output wdata, input rdata);
  modport slave  (input rd, input wr, input addr, input wdata, output rdata);
endinterface

// File: rtl/cache_controller.sv
// Set-associative write-through/write-allocate cache over an internal 64K x 32 RAM.
// Optional hit/miss counters are enabled by defining CACHE_STATS_EN.
module cache_controller #(
  parameter int unsigned NUM_SETS = 64,
  parameter int unsigned NUM_WAYS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  cache_controller_if.slave   bus
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]         hit_count,
  output logic [31:0]         miss_count
`endif
);

  localparam int unsigned IDX_W = $clog2(NUM_SETS);
  localparam int unsigned TAG_W = 16 - IDX_W;
  localparam int unsigned WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  logic [31:0]         mem_q   [65536];
  logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
  logic [WAY_W-1:0]    ptr_q   [NUM_SETS];
  logic [TAG_W-1:0]    tag_q   [NUM_SETS][NUM_WAYS];
  logic [31:0]         data_q  [NUM_SETS][NUM_WAYS];

  logic        stage_vld_q, stage_vld_d;
  logic [31:0] stage_q, stage_d;
  logic [31:0] rdata_q;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic             inv_found;
  logic [WAY_W-1:0] inv_way;
  logic [WAY_W-1:0] victim;
  logic [WAY_W-1:0] ptr_d;
  logic             rd_op;
  logic             alloc;
  logic [31:0]      mem_rd;

  assign idx    = bus.addr[IDX_W-1:0];
  assign tag    = bus.addr[15:IDX_W];
  assign mem_rd = mem_q[bus.addr];
  assign rd_op  = bus.rd && !bus.wr;

  // Tag compare and lowest-invalid search across the indexed set.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[idx][w] && (tag_q[idx][w] == tag) && !hit) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[idx][w] && !inv_found) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
  end

  always_comb begin
    victim      = inv_found ? inv_way : ptr_q[idx];
    ptr_d       = (ptr_q[idx] == WAY_W'(NUM_WAYS - 1)) ? '0 : ptr_q[idx] + 1'b1;
    alloc       = (bus.wr || bus.rd) && !hit;
    stage_vld_d = rd_op;
    stage_d     = stage_q;
    if (rd_op) begin
      stage_d = hit ? data_q[idx][hit_way] : mem_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        ptr_q[s]   <= '0;
      end
      stage_vld_q <= 1'b0;
      stage_q     <= '0;
      rdata_q     <= '0;
    end else begin
      if (alloc) begin
        valid_q[idx][victim] <= 1'b1;
        if (!inv_found) begin
          ptr_q[idx] <= ptr_d;
        end
      end
      stage_vld_q <= stage_vld_d;
      stage_q     <= stage_d;
      if (stage_vld_q) begin
        rdata_q <= stage_q;
      end
    end
  end

  // RAM and line payloads are deliberately outside reset; valid bits gate their use.
  always_ff @(posedge clk) begin
    if (bus.wr) begin
      mem_q[bus.addr] <= bus.wdata;
      if (hit) begin
        data_q[idx][hit_way] <= bus.wdata;
      end else begin
        data_q[idx][victim] <= bus.wdata;
        tag_q[idx][victim]  <= tag;
      end
    end else if (bus.rd && !hit) begin
      data_q[idx][victim] <= mem_rd;
      tag_q[idx][victim]  <= tag;
    end
  end

  assign bus.rdata = rdata_q;

`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (rd_op) begin
      if (hit) hit_cnt_q  <= hit_cnt_q + 32'd1;
      else     miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Directed self-checking bench for cache_controller: data path, eviction order,
// rd/wr collision, pipelining, snapshot reads and mid-read reset.
module tb_cache_controller;

  logic clk;
  logic rst_n;
  int   total;
  int   passed;

  cache_controller_if bus();

`ifdef CACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  cache_controller #(.NUM_SETS(64), .NUM_WAYS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef CACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // All driving happens just after a falling edge; each task ends on a falling edge.
  task automatic do_write(input logic [15:0] a, input logic [31:0] d);
    bus.wr = 1'b1; bus.rd = 1'b0; bus.addr = a; bus.wdata = d;
    @(negedge clk);
    bus.wr = 1'b0;
  endtask

  task automatic do_read(input logic [15:0] a);
    bus.rd = 1'b1; bus.wr = 1'b0; bus.addr = a;
    @(negedge clk);
    bus.rd = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    total = 0; passed = 0;
    rst_n = 1'b0;
    bus.rd = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.wdata = '0;
    repeat (2) @(negedge clk);
    check("reset_rdata", bus.rdata, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    do_read(16'h0004);
    check("cold_read", bus.rdata, 32'h0000_0000);

    do_write(16'h0004, 32'h1111_AAAA);
    do_read(16'h0004);
    check("write_then_read", bus.rdata, 32'h1111_AAAA);

    do_write(16'h0004, 32'hAAAA_0001);
    do_write(16'h0404, 32'hAAAA_0002);
    do_write(16'h0804, 32'hAAAA_0003);
    do_write(16'h0C04, 32'hAAAA_0004);
    do_read(16'h0C04); check("set4_way3", bus.rdata, 32'hAAAA_0004);
    do_read(16'h0004); check("set4_way0", bus.rdata, 32'hAAAA_0001);
    do_read(16'h0404); check("set4_way1", bus.rdata, 32'hAAAA_0002);
    do_read(16'h0804); check("set4_way2", bus.rdata, 32'hAAAA_0003);

    // Round-robin: 0x1004 -> way0, then 0x0004 -> way1, 0x0404 -> way2, 0x0804 -> way3.
    do_write(16'h1004, 32'hAAAA_0005);
    do_read(16'h1004); check("evict_new", bus.rdata, 32'hAAAA_0005);
    do_read(16'h0004); check("evicted_refill", bus.rdata, 32'hAAAA_0001);
    do_read(16'h0404); check("refill_0404", bus.rdata, 32'hAAAA_0002);
    do_read(16'h0804); check("refill_0804", bus.rdata, 32'hAAAA_0003);
    do_read(16'h1004); check("way0_kept", bus.rdata, 32'hAAAA_0005);

    do_write(16'hFFFF, 32'hDEAD_BEEF);
    do_read(16'hFFFF); check("top_addr", bus.rdata, 32'hDEAD_BEEF);

    repeat (3) @(negedge clk);
    check("idle_hold", bus.rdata, 32'hDEAD_BEEF);

    bus.rd = 1'b1; bus.wr = 1'b1; bus.addr = 16'h0010; bus.wdata = 32'h5;
    @(negedge clk);
    bus.rd = 1'b0; bus.wr = 1'b0;
    @(negedge clk);
    check("rdwr_collision_rdata", bus.rdata, 32'hDEAD_BEEF);
    do_read(16'h0010); check("rdwr_write_done", bus.rdata, 32'h0000_0005);

    bus.rd = 1'b1; bus.addr = 16'h0004;
    @(negedge clk);
    bus.addr = 16'hFFFF;
    @(negedge clk);
    check("b2b_first", bus.rdata, 32'hAAAA_0001);
    bus.rd = 1'b0;
    @(negedge clk);
    check("b2b_second", bus.rdata, 32'hDEAD_BEEF);

    bus.rd = 1'b1; bus.addr = 16'h0010;
    @(negedge clk);
    bus.rd = 1'b0; bus.wr = 1'b1; bus.wdata = 32'h77;
    @(negedge clk);
    bus.wr = 1'b0;
    check("snapshot_old", bus.rdata, 32'h0000_0005);
    do_read(16'h0010); check("snapshot_new", bus.rdata, 32'h0000_0077);

`ifdef CACHE_STATS_EN
    check("hit_count", hit_count, 32'd13);
    check("miss_count", miss_count, 32'd4);
`endif

    bus.rd = 1'b1; bus.addr = 16'hFFFF;
    @(negedge clk);
    bus.rd = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midread_reset", bus.rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("pending_discarded", bus.rdata, 32'h0);
`ifdef CACHE_STATS_EN
    check("hit_count_rst", hit_count, 32'd0);
    check("miss_count_rst", miss_count, 32'd0);
`endif

    do_read(16'h1004); check("ram_survives_reset", bus.rdata, 32'hAAAA_0005);
`ifdef CACHE_STATS_EN
    check("miss_after_rst", miss_count, 32'd1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
